video_stream_packer: RTL and testbench

VIDEO_STREAM_PACKER -- requirements
Module: video_stream_packer

---
 rtl/video_stream_packer_pkg.sv | 15 +
 rtl/video_stream_packer.sv | 143 ++++++++++++++
 tb/tb_video_stream_packer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_stream_packer_pkg.sv
// Shared constants and types for the RGB888 -> 32-bit AXI-Stream packer.
package video_stream_packer_pkg;

    localparam int DEFAULT_PIX_PER_LINE = 640;
    localparam int DEFAULT_LINES        = 480;

    // Position of the current pixel inside its 4-pixel / 3-word group.
    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

endpackage

// File: rtl/video_stream_packer.sv
// Packs a 24-bit pixel stream into 32-bit AXI-Stream words, three words per
// four pixels, with start-of-frame on tuser and end-of-line on tlast.
module video_stream_packer
    import video_stream_packer_pkg::*;
#(
    parameter int PIX_PER_LINE = DEFAULT_PIX_PER_LINE,
    parameter int LINES        = DEFAULT_LINES
) (
    input  logic        out_stream_aclk,
    input  logic        axi_resetn,
    input  logic [7:0]  pix_r,
    input  logic [7:0]  pix_g,
    input  logic [7:0]  pix_b,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [31:0] out_stream_tdata,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        out_stream_tuser,
    output logic        out_stream_tlast,
    output logic [3:0]  out_stream_tkeep,
    output logic [15:0] frame_count
);

    localparam int XW = $clog2(PIX_PER_LINE);
    localparam int YW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(PIX_PER_LINE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINES - 1);

    phase_t        phase_q, phase_d;
    logic [23:0]   residue_q, residue_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic          tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic [15:0]   frameCount_q, frameCount_d;

    logic          accept;
    logic          wordLoad;
    logic [31:0]   word;

    // Stalled only while a word is held and downstream refuses it.
    assign pix_ready = !tvalid_q || out_stream_tready;
    assign accept    = pix_valid && pix_ready;

    always_comb begin
        phase_d      = phase_q;
        residue_d    = residue_q;
        x_d          = x_q;
        y_d          = y_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        frameCount_d = frameCount_q;
        wordLoad     = 1'b0;
        word         = '0;

        if (tvalid_q && out_stream_tready) begin
            tvalid_d = 1'b0;
        end

        if (accept) begin
            // Residue is kept right-aligned so the oldest byte lands in word bits 7:0.
            case (phase_q)
                PH0: begin
                    residue_d = {pix_b, pix_g, pix_r};
                end
                PH1: begin
                    word      = {pix_r, residue_q};
                    residue_d = {8'h00, pix_b, pix_g};
                    wordLoad  = 1'b1;
                end
                PH2: begin
                    word      = {pix_g, pix_r, residue_q[15:0]};
                    residue_d = {16'h0000, pix_b};
                    wordLoad  = 1'b1;
                end
                PH3: begin
                    word      = {pix_b, pix_g, pix_r, residue_q[7:0]};
                    residue_d = '0;
                    wordLoad  = 1'b1;
                end
                default: ;
            endcase
            phase_d = phase_t'(phase_q + 2'd1);

            if (wordLoad) begin
                tdata_d  = word;
                tvalid_d = 1'b1;
                tuser_d  = (x_q == XW'(1)) && (y_q == '0);
                tlast_d  = (x_q == X_LAST);
            end

            if (x_q == X_LAST) begin
                x_d     = '0;
                phase_d = PH0;
                if (y_q == Y_LAST) begin
                    y_d          = '0;
                    frameCount_d = frameCount_q + 16'd1;
                end else begin
                    y_d = y_q + YW'(1);
                end
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            phase_q      <= PH0;
            residue_q    <= '0;
            x_q          <= '0;
            y_q          <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            frameCount_q <= '0;
        end else begin
            phase_q      <= phase_d;
            residue_q    <= residue_d;
            x_q          <= x_d;
            y_q          <= y_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tvalid = tvalid_q;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tkeep  = 4'hF;
    assign frame_count       = frameCount_q;

endmodule

// File: tb/tb_video_stream_packer.sv
// Self-checking bench for video_stream_packer: vector table, reset/stall
// sequences and a byte-stream scoreboard over two small frames.
module tb_video_stream_packer;

    localparam int PPL    = 16;
    localparam int NLINES = 4;
    localparam int WPL    = PPL * 3 / 4;

    logic        clk = 1'b0;
    logic        axi_resetn = 1'b1;
    logic [7:0]  pix_r = '0;
    logic [7:0]  pix_g = '0;
    logic [7:0]  pix_b = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [31:0] out_stream_tdata;
    logic        out_stream_tvalid;
    logic        out_stream_tready = 1'b0;
    logic        out_stream_tuser;
    logic        out_stream_tlast;
    logic [3:0]  out_stream_tkeep;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    video_stream_packer #(
        .PIX_PER_LINE(PPL),
        .LINES(NLINES)
    ) dut (
        .out_stream_aclk(clk),
        .axi_resetn(axi_resetn),
        .pix_r(pix_r),
        .pix_g(pix_g),
        .pix_b(pix_b),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .out_stream_tdata(out_stream_tdata),
        .out_stream_tvalid(out_stream_tvalid),
        .out_stream_tready(out_stream_tready),
        .out_stream_tuser(out_stream_tuser),
        .out_stream_tlast(out_stream_tlast),
        .out_stream_tkeep(out_stream_tkeep),
        .frame_count(frame_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        user;
        logic        last;
    } exp_t;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        expValid;
        logic [31:0] expData;
        logic        expUser;
    } vec_t;

    vec_t       vecs[4];
    exp_t       expQ[$];
    logic [7:0] byteQ[$];
    int         mx = 0;
    int         my = 0;
    int         expFrames = 0;
    int         wordsInLine = 0;
    int         checks = 0;
    int         errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        byteQ.delete();
        expQ.delete();
        mx = 0;
        my = 0;
        expFrames = 0;
        wordsInLine = 0;
    endtask

    // Reference model: a plain byte FIFO; every 4 bytes make one word.
    task automatic modelAccept(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        byteQ.push_back(r);
        byteQ.push_back(g);
        byteQ.push_back(b);
        if (byteQ.size() >= 4) begin
            e.data = {byteQ[3], byteQ[2], byteQ[1], byteQ[0]};
            repeat (4) void'(byteQ.pop_front());
            e.user = (mx == 1) && (my == 0);
            e.last = (mx == PPL - 1);
            expQ.push_back(e);
        end
        if (mx == PPL - 1) begin
            mx = 0;
            if (my == NLINES - 1) begin
                my = 0;
                expFrames = (expFrames + 1) % 65536;
            end else begin
                my++;
            end
        end else begin
            mx++;
        end
    endtask

    task automatic popCompare();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word actual=0x%08h expected=none", out_stream_tdata);
        end else begin
            e = expQ.pop_front();
            checkOutput("sb_tdata", out_stream_tdata, e.data);
            checkOutput("sb_tuser", 32'(out_stream_tuser), 32'(e.user));
            checkOutput("sb_tlast", 32'(out_stream_tlast), 32'(e.last));
            checkOutput("sb_tkeep", 32'(out_stream_tkeep), 32'h0000000F);
            wordsInLine++;
            if (out_stream_tlast) begin
                checkOutput("words_per_line", wordsInLine, WPL);
                wordsInLine = 0;
            end
        end
    endtask

    // One clock of stimulus; handshakes are resolved just after the falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b, input logic rdy);
        @(negedge clk);
        pix_valid = v;
        pix_r = r;
        pix_g = g;
        pix_b = b;
        out_stream_tready = rdy;
        #1;
        checkOutput("pix_ready_eq", 32'(pix_ready), 32'(!out_stream_tvalid || rdy));
        checkOutput("frame_count", 32'(frame_count), expFrames);
        if (out_stream_tvalid && rdy) popCompare();
        if (v && pix_ready) modelAccept(r, g, b);
        @(posedge clk);
    endtask

    task automatic doReset(input int holdCycles);
        @(negedge clk);
        axi_resetn = 1'b0;
        pix_valid = 1'b1;
        out_stream_tready = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_tvalid", 32'(out_stream_tvalid), 32'd0);
        checkOutput("rst_tuser", 32'(out_stream_tuser), 32'd0);
        checkOutput("rst_tlast", 32'(out_stream_tlast), 32'd0);
        checkOutput("rst_tdata", out_stream_tdata, 32'd0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
        checkOutput("rst_pix_ready", 32'(pix_ready), 32'd1);
        repeat (holdCycles) @(negedge clk);
        #1;
        checkOutput("rst_no_accept", 32'(out_stream_tvalid), 32'd0);
        @(negedge clk);
        axi_resetn = 1'b1;
        pix_valid = 1'b0;
    endtask

    task automatic runTable();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, vecs[i].r, vecs[i].g, vecs[i].b, 1'b1);
            #2;
            checkOutput("tbl_tvalid", 32'(out_stream_tvalid), 32'(vecs[i].expValid));
            if (vecs[i].expValid) begin
                checkOutput("tbl_tdata", out_stream_tdata, vecs[i].expData);
                checkOutput("tbl_tuser", 32'(out_stream_tuser), 32'(vecs[i].expUser));
            end
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        #2;
        checkOutput("tvalid_fall", 32'(out_stream_tvalid), 32'd0);
    endtask

    initial begin
        int          guard;
        logic [31:0] heldData;

        vecs[0] = '{8'h00, 8'h10, 8'h20, 1'b0, 32'h00000000, 1'b0};
        vecs[1] = '{8'h01, 8'h11, 8'h21, 1'b1, 32'h01201000, 1'b1};
        vecs[2] = '{8'h02, 8'h12, 8'h22, 1'b1, 32'h12022111, 1'b0};
        vecs[3] = '{8'h03, 8'h13, 8'h23, 1'b1, 32'h23130322, 1'b0};

        doReset(3);
        runTable();

        // Abandon a group after three pixels; stale b2 must not leak into the next frame.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end
        doReset(2);
        runTable();

        guard = 0;
        do begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            #2;
            guard++;
        end while (!out_stream_tvalid && guard < 8);
        if (!out_stream_tvalid) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_setup actual=no_word expected=word_pending");
        end else begin
            heldData = out_stream_tdata;
            for (int i = 0; i < 10; i++) begin
                applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
                #2;
                checkOutput("stall_tdata", out_stream_tdata, heldData);
                checkOutput("stall_pix_ready", 32'(pix_ready), 32'd0);
                checkOutput("stall_tvalid", 32'(out_stream_tvalid), 32'd1);
            end
        end

        guard = 0;
        while (expFrames < 2 && guard < 20000) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)));
            guard++;
        end
        if (expFrames < 2) begin
            checks++;
            errors++;
            $display("[TB] FAIL stream_timeout actual=%0d expected=2 frames", expFrames);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        end

        guard = 0;
        while (expQ.size() > 0 && guard < 100) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
            guard++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=%0d expected=0 pending", expQ.size());
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        #2;
        checkOutput("final_frame_count", 32'(frame_count), 32'd2);
        checkOutput("final_tvalid", 32'(out_stream_tvalid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
